pe_core_param: RTL

Parametrised next-generation processing element for the PE array. It has NUM_IN token inports, each buffered by its own FIFO with backpressure to the upstream PE. A config-word stream selects the opcode, the operand sources, the consumer mask and an iteration count. One registered result token is fanned out to up to NUM_POST consumers, gated by their backpressure. Constants can be reloaded at runtime over the config port.

---
 rtl/pe_pkg.sv | 50 +++++
 rtl/pe_in_fifo.sv | 62 ++++++
 rtl/pe_core_param.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared opcodes, op-word layout, config-port layout and FSM states
// for the pe_core_param processing element and its input FIFOs.
package pe_pkg;

  // ALU opcodes (codes 12..15 behave as PASS A)
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_MIN  = 4'd8;
  localparam logic [3:0] OP_MAX  = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;
  localparam logic [3:0] OP_EQ   = 4'd11;

  // Operand select code that picks the runtime constant instead of a FIFO
  localparam logic [1:0] SEL_CONST = 2'd3;

  // Op-word field layout
  localparam int OPW_OP_LSB   = 0;
  localparam int OPW_OP_W     = 4;
  localparam int OPW_SELA_LSB = 4;
  localparam int OPW_SELB_LSB = 6;
  localparam int OPW_SEL_W    = 2;
  localparam int OPW_MASK_LSB = 8;
  localparam int OPW_MASK_W   = 8;
  localparam int OPW_ITER_LSB = 16;
  localparam int OPW_ITER_W   = 16;

  // Config port: one valid bit above a 32-bit payload
  localparam int CFG_PAYLOAD_W = 32;
  localparam int CFG_VLD_BIT   = 32;
  localparam int CFG_W         = 33;

  // Token = {valid, tag, data}
  function automatic int tok_w(input int data_w, input int tag_w);
    return data_w + tag_w + 1;
  endfunction

  typedef enum logic [1:0] {
    UNCFG     = 2'd0,
    CFG_CONST = 2'd1,
    RUN       = 2'd2,
    DONE      = 2'd3
  } pe_state_e;

endpackage

// File: rtl/pe_in_fifo.sv
// pe_in_fifo: per-inport token FIFO. Backpressure comes from the registered
// count only, so a full FIFO refuses a push even in a cycle where it pops.
module pe_in_fifo
  import pe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push_vld,
  input  logic [TAG_W-1:0]  i_push_tag,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_ready,
  output logic              o_nempty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [DATA_W-1:0] o_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [TAG_W+DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_push;
  logic                    w_pop;

  assign o_ready  = (r_cnt < DEPTH_C);
  assign o_nempty = (r_cnt != '0);
  assign w_push   = i_push_vld & o_ready;
  assign w_pop    = i_pop & o_nempty;

  // Pointer and occupancy tracking; reset empties the FIFO immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Token storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_push_tag, i_push_data};
  end

  assign {o_tag, o_data} = r_mem[r_rd_ptr];

endmodule

// File: rtl/pe_core_param.sv
// pe_core_param: parametrised PE with NUM_IN buffered token inports, a
// config-word driven op/operand/consumer selection, an iteration limit and a
// single registered result token fanned out to NUM_POST consumers.
// Optional build macro: PE_DROP_DETECT_EN adds err_drop / drop_cnt outputs
// that count tokens presented to a full inport.
module pe_core_param
  import pe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 3,
  parameter int NUM_IN     = 3,
  parameter int NUM_POST   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CFG_W-1:0]                     PE_Configure_Inport,
  input  logic [NUM_IN*(DATA_W+TAG_W+1)-1:0]   PE_Inport,
  input  logic [NUM_POST-1:0]                  Post_PE_Bp,
  output logic [DATA_W+TAG_W:0]                PE_Outport,
  output logic [NUM_IN-1:0]                    Pre_PE_Bp,
  output logic                                 cfg_done
`ifdef PE_DROP_DETECT_EN
  ,
  output logic                                 err_drop,
  output logic [7:0]                           drop_cnt
`endif
);

  localparam int W_TOK = tok_w(DATA_W, TAG_W);

  // Widen/truncate the 32-bit config payload to the data width
  function automatic logic [DATA_W-1:0] cfg_to_data(input logic [CFG_PAYLOAD_W-1:0] p);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < CFG_PAYLOAD_W) r[i] = p[i];
    end
    return r;
  endfunction

  // Result computation, truncated to DATA_W
  function automatic logic [DATA_W-1:0] alu(input logic [3:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [DATA_W-1:0]        r;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SHL:  r = a << b[4:0];
      OP_SHR:  r = a >> b[4:0];
      OP_MIN:  r = (sa < sb) ? a : b;
      OP_MAX:  r = (sa > sb) ? a : b;
      OP_PASS: r = a;
      OP_EQ:   r = (a == b) ? DATA_W'(1) : '0;
      default: r = a;
    endcase
    return r;
  endfunction

  // Config port split
  logic                     w_cfg_vld;
  logic [CFG_PAYLOAD_W-1:0] w_cfg_payload;
  assign w_cfg_vld     = PE_Configure_Inport[CFG_VLD_BIT];
  assign w_cfg_payload = PE_Configure_Inport[CFG_PAYLOAD_W-1:0];

  // Control state
  pe_state_e               r_state;
  pe_state_e               w_state_nxt;
  logic                    w_ld_op;
  logic                    w_ld_const;
  logic [31:0]             r_op_word;
  logic [DATA_W-1:0]       r_const;
  logic [OPW_ITER_W-1:0]   r_iter_cnt;
  logic [OPW_ITER_W-1:0]   w_iter_nxt;

  // Op-word fields
  logic [OPW_OP_W-1:0]     w_op;
  logic [OPW_SEL_W-1:0]    w_sel_a;
  logic [OPW_SEL_W-1:0]    w_sel_b;
  logic [OPW_MASK_W-1:0]   w_mask;
  logic [OPW_ITER_W-1:0]   w_iter;
  assign w_op    = r_op_word[OPW_OP_LSB   +: OPW_OP_W];
  assign w_sel_a = r_op_word[OPW_SELA_LSB +: OPW_SEL_W];
  assign w_sel_b = r_op_word[OPW_SELB_LSB +: OPW_SEL_W];
  assign w_mask  = r_op_word[OPW_MASK_LSB +: OPW_MASK_W];
  assign w_iter  = r_op_word[OPW_ITER_LSB +: OPW_ITER_W];

  // FIFO bank
  logic [NUM_IN-1:0] w_fifo_nempty;
  logic [NUM_IN-1:0] w_pop;
  logic [TAG_W-1:0]  w_fifo_tag  [NUM_IN];
  logic [DATA_W-1:0] w_fifo_data [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_fifo
    pe_in_fifo #(
      .DATA_W     (DATA_W),
      .TAG_W      (TAG_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push_vld  (PE_Inport[g*W_TOK + W_TOK - 1]),
      .i_push_tag  (PE_Inport[g*W_TOK + DATA_W +: TAG_W]),
      .i_push_data (PE_Inport[g*W_TOK +: DATA_W]),
      .i_pop       (w_pop[g]),
      .o_ready     (Pre_PE_Bp[g]),
      .o_nempty    (w_fifo_nempty[g]),
      .o_tag       (w_fifo_tag[g]),
      .o_data      (w_fifo_data[g])
    );
  end

  // FIFO heads padded to the full 2-bit select range so the selects index safely
  logic [3:0]        w_nempty4;
  logic [TAG_W-1:0]  w_tag4  [4];
  logic [DATA_W-1:0] w_data4 [4];

  // Build the padded head view of the FIFO bank
  always_comb begin
    w_nempty4 = '0;
    for (int k = 0; k < 4; k++) begin
      w_tag4[k]  = '0;
      w_data4[k] = '0;
    end
    for (int k = 0; k < NUM_IN; k++) begin
      w_nempty4[k] = w_fifo_nempty[k];
      w_tag4[k]    = w_fifo_tag[k];
      w_data4[k]   = w_fifo_data[k];
    end
  end

  // Operand selection: codes outside the populated inports fall back to the constant
  logic              w_a_const;
  logic              w_b_const;
  logic              w_a_ok;
  logic              w_b_ok;
  logic [DATA_W-1:0] w_a_data;
  logic [DATA_W-1:0] w_b_data;
  assign w_a_const = (w_sel_a == SEL_CONST) || (int'(w_sel_a) >= NUM_IN);
  assign w_b_const = (w_sel_b == SEL_CONST) || (int'(w_sel_b) >= NUM_IN);
  assign w_a_ok    = w_a_const | w_nempty4[w_sel_a];
  assign w_b_ok    = w_b_const | w_nempty4[w_sel_b];
  assign w_a_data  = w_a_const ? r_const : w_data4[w_sel_a];
  assign w_b_data  = w_b_const ? r_const : w_data4[w_sel_b];

  // Downstream readiness: only consumers enabled in the mask can stall us
  logic w_ds_ready;
  always_comb begin
    w_ds_ready = 1'b1;
    for (int k = 0; k < NUM_POST; k++) begin
      w_ds_ready = w_ds_ready & (Post_PE_Bp[k] | ~w_mask[k]);
    end
  end

  // Fire and result registers
  logic              r_res_vld_p1;
  logic [TAG_W-1:0]  r_res_tag_p1;
  logic [DATA_W-1:0] r_res_data_p1;
  logic              w_fire;
  logic [DATA_W-1:0] w_res_data;
  logic [TAG_W-1:0]  w_res_tag;

  assign w_fire     = (r_state == RUN) & w_a_ok & w_b_ok & (~r_res_vld_p1 | w_ds_ready);
  assign w_res_data = alu(w_op, w_a_data, w_b_data);
  assign w_res_tag  = w_a_const ? '0 : w_tag4[w_sel_a];
  assign w_iter_nxt = r_iter_cnt + 1'b1;

  // Pop each selected FIFO once per fire, even when A and B share an inport
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_pop[k] = w_fire & ((!w_a_const && (int'(w_sel_a) == k)) ||
                           (!w_b_const && (int'(w_sel_b) == k)));
    end
  end

  // Result register: load on fire, drop valid once consumed, otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_vld_p1  <= 1'b0;
      r_res_tag_p1  <= '0;
      r_res_data_p1 <= '0;
    end else if (w_fire) begin
      r_res_vld_p1  <= 1'b1;
      r_res_tag_p1  <= w_res_tag;
      r_res_data_p1 <= w_res_data;
    end else if (w_ds_ready) begin
      r_res_vld_p1  <= 1'b0;
    end
  end

  assign PE_Outport = {r_res_vld_p1, r_res_tag_p1, r_res_data_p1};

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= UNCFG;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and config-load strobes
  always_comb begin
    w_state_nxt = r_state;
    w_ld_op     = 1'b0;
    w_ld_const  = 1'b0;
    case (r_state)
      UNCFG: begin
        if (w_cfg_vld) begin
          w_ld_op     = 1'b1;
          w_state_nxt = CFG_CONST;
        end
      end
      CFG_CONST: begin
        if (w_cfg_vld) begin
          w_ld_const  = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_cfg_vld) w_ld_const = 1'b1;
        if (w_fire && (w_iter != '0) && (w_iter_nxt == w_iter)) w_state_nxt = DONE;
      end
      DONE: begin
        if (w_cfg_vld) begin
          w_ld_op     = 1'b1;
          w_state_nxt = CFG_CONST;
        end
      end
      default: w_state_nxt = UNCFG;
    endcase
  end

  assign cfg_done = (r_state == DONE);

  // Op word and constant capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op_word <= '0;
      r_const   <= '0;
    end else begin
      if (w_ld_op)    r_op_word <= w_cfg_payload;
      if (w_ld_const) r_const   <= cfg_to_data(w_cfg_payload);
    end
  end

  // Iteration counter: restarts with every new op word, counts fires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_iter_cnt <= '0;
    else if (w_ld_op) r_iter_cnt <= '0;
    else if (w_fire)  r_iter_cnt <= w_iter_nxt;
  end

`ifdef PE_DROP_DETECT_EN
  // Saturating add for the drop counter
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [1:0] w_drop_num;
  logic       r_err_drop;
  logic [7:0] r_drop_cnt;

  // Count inports presenting a token while refusing it this cycle
  always_comb begin
    w_drop_num = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_drop_num = w_drop_num + 2'(PE_Inport[k*W_TOK + W_TOK - 1] & ~Pre_PE_Bp[k]);
    end
  end

  // Sticky drop flag and saturating drop counter, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_drop <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop_num != '0) begin
      r_err_drop <= 1'b1;
      r_drop_cnt <= sat_add8(r_drop_cnt, w_drop_num);
    end
  end

  assign err_drop = r_err_drop;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule
